fifo_umbral: RTL and testbench

- Synchronous FIFO with programmable almost-empty/almost-full thresholds ("umbrales").
- Sits directly upstream of the flow-control FSM: one instance per main/VC0/VC1/D0/D1 queue.
- The FSM's `*_low`/`*_high` outputs drive `umbral_low`/`umbral_high`.
- This block's `empty` and `error` feed one bit each of the FSM's `empties`/`errors` buses.

---
 rtl/fifo_umbral.sv | 93 +++++++++
 tb/tb_fifo_umbral.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with programmable almost-empty/almost-full thresholds.
// Optional FIFO_PEAK_EN adds peak_count, the highest occupancy since reset/init.
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH:0]   umbral_low,
  input  logic [ADDR_WIDTH:0]   umbral_high,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
`ifdef FIFO_PEAK_EN
  output logic [ADDR_WIDTH:0]   peak_count,
`endif
  output logic                  error
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  typedef enum logic {CONFIG, RUN} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr;
  logic [ADDR_WIDTH:0] low_q, high_q, count_nxt;
  logic pop_ok, push_ok, ovf, unf;
  function automatic logic [ADDR_WIDTH:0] clamp(input logic [ADDR_WIDTH:0] v);
    return v > DEPTH_C ? DEPTH_C : v;
  endfunction
  assign empty        = fifo_count == '0;
  assign full         = fifo_count == DEPTH_C;
  assign almost_empty = fifo_count <= low_q;
  assign almost_full  = fifo_count >= high_q;
  // CONFIG always leaves the FIFO flushed, so the first RUN edge can only accept a push
  always_comb begin
    pop_ok    = !init && pop && state == RUN && !empty;
    push_ok   = !init && push && (state == CONFIG || !full || pop_ok);
    ovf       = !init && push && !push_ok;
    unf       = !init && pop && !pop_ok;
    count_nxt = fifo_count + {{ADDR_WIDTH{1'b0}}, push_ok} - {{ADDR_WIDTH{1'b0}}, pop_ok};
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CONFIG;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      error      <= 1'b0;
      low_q      <= (ADDR_WIDTH + 1)'(1);
      high_q     <= DEPTH_C - 1'b1;
`ifdef FIFO_PEAK_EN
      peak_count <= '0;
`endif
    end else if (init) begin
      state      <= CONFIG;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      valid_out  <= 1'b0;
      error      <= 1'b0;
      low_q      <= clamp(umbral_low);
      high_q     <= clamp(umbral_high);
`ifdef FIFO_PEAK_EN
      peak_count <= '0;
`endif
    end else begin
      state      <= RUN;
      valid_out  <= pop_ok;
      fifo_count <= count_nxt;
      error      <= error | ovf | unf;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
`ifdef FIFO_PEAK_EN
      peak_count <= count_nxt > peak_count ? count_nxt : peak_count;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: directed self-checking bench for fifo_umbral.
module tb_fifo_umbral;
  logic clk = 1'b0, reset = 1'b1, init = 1'b0, push = 1'b0, pop = 1'b0;
  logic [4:0] umbral_low = 5'd0, umbral_high = 5'd0;
  logic [5:0] data_in = 6'd0, data_out;
  logic valid_out, empty, full, almost_empty, almost_full, error;
  logic [4:0] fifo_count;
`ifdef FIFO_PEAK_EN
  logic [4:0] peak_count;
`endif
  int checks = 0, failures = 0;
  fifo_umbral dut (
    .clk(clk), .reset(reset), .init(init), .umbral_low(umbral_low), .umbral_high(umbral_high),
    .push(push), .data_in(data_in), .pop(pop), .data_out(data_out), .valid_out(valid_out),
    .fifo_count(fifo_count), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full),
`ifdef FIFO_PEAK_EN
    .peak_count(peak_count),
`endif
    .error(error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_init(input int lo, input int hi);
    init = 1'b1;
    umbral_low = 5'(lo);
    umbral_high = 5'(hi);
    tick();
    init = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_aempty", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_error", error, 0);
    check("rst_count", fifo_count, 0);
    check("rst_valid", valid_out, 0);
    do_init(2, 5);
    for (int i = 1; i <= 6; i++) begin
      push = 1'b1;
      data_in = 6'(i);
      tick();
      check("wm_aempty", almost_empty, i <= 2);
      check("wm_afull", almost_full, i >= 5);
    end
    push = 1'b0;
    check("wm_count", fifo_count, 6);
`ifdef FIFO_PEAK_EN
    check("wm_peak", peak_count, 6);
`endif
    for (int i = 1; i <= 6; i++) begin
      pop = 1'b1;
      tick();
      check("rd_valid", valid_out, 1);
      check("rd_data", data_out, i);
    end
    pop = 1'b0;
    tick();
    check("rd_idle_valid", valid_out, 0);
    check("rd_idle_hold", data_out, 6);
    check("rd_empty", empty, 1);
    for (int i = 1; i <= 17; i++) begin
      push = 1'b1;
      data_in = 6'(16 + i);
      tick();
      if (i == 16) begin
        check("ovf_full16", full, 1);
        check("ovf_err16", error, 0);
      end
    end
    push = 1'b0;
    check("ovf_count", fifo_count, 16);
    check("ovf_err", error, 1);
    tick();
    check("ovf_sticky", error, 1);
    do_init(0, 31);
    check("clr_count", fifo_count, 0);
    check("clr_err", error, 0);
    check("clr_afull", almost_full, 0);
    check("clr_aempty", almost_empty, 1);
    pop = 1'b1;
    tick();
    check("unf_err", error, 1);
    check("unf_valid", valid_out, 0);
    check("unf_count", fifo_count, 0);
    push = 1'b1;
    data_in = 6'h2A;
    tick();
    check("unf_pp_count", fifo_count, 1);
    check("unf_pp_valid", valid_out, 0);
    push = 1'b0;
    tick();
    pop = 1'b0;
    check("unf_rd_valid", valid_out, 1);
    check("unf_rd_data", data_out, 'h2A);
    check("unf_rd_empty", empty, 1);
    do_init(0, 31);
    check("init2_err", error, 0);
    for (int i = 0; i < 16; i++) begin
      push = 1'b1;
      data_in = 6'(i);
      tick();
      if (i == 14) check("clamp_af15", almost_full, 0);
    end
    check("clamp_af16", almost_full, 1);
    check("wrap_full", full, 1);
    for (int k = 0; k < 20; k++) begin
      push = 1'b1;
      pop = 1'b1;
      data_in = 6'(16 + k);
      tick();
      check("wrap_data", data_out, k);
      check("wrap_valid", valid_out, 1);
      check("wrap_count", fifo_count, 16);
      check("wrap_err", error, 0);
    end
    push = 1'b0;
    pop = 1'b0;
    do_init(1, 15);
`ifdef FIFO_PEAK_EN
    check("init_peak", peak_count, 0);
`endif
    for (int i = 0; i < 7; i++) begin
      push = 1'b1;
      data_in = 6'(40 + i);
      tick();
    end
    check("abort_pre_count", fifo_count, 7);
    check("abort_pre_data", data_out, 19);
`ifdef FIFO_PEAK_EN
    check("abort_pre_peak", peak_count, 7);
`endif
    #2 reset = 1'b1;
    #1;
    check("abort_count", fifo_count, 0);
    check("abort_empty", empty, 1);
    check("abort_aempty", almost_empty, 1);
    check("abort_afull", almost_full, 0);
    check("abort_data", data_out, 0);
    check("abort_valid", valid_out, 0);
    check("abort_err", error, 0);
`ifdef FIFO_PEAK_EN
    check("abort_peak", peak_count, 0);
`endif
    push = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_count", fifo_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
